// File: rtl/ga25_pkg.sv
// Shared definitions for the GA25 palette stage: CPU FSM states, palette entry
// layout (xBBBBBGGGGGRRRRR) and the 5-to-8 bit colour expansion.
package ga25_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PEND    = 2'd1;
    localparam logic [1:0] ST_ISSUE   = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'd3;

    localparam int C_W   = 5;
    localparam int R_LSB = 0;
    localparam int G_LSB = 5;
    localparam int B_LSB = 10;

    // Replicating the top bits makes full scale map to full scale (1F -> FF).
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/ga25_palette_if.sv
// CPU access port of the palette: select/read/write strobes, address, data
// in both directions and the busy hold-off.
interface ga25_palette_if #(parameter int PAL_AW = 11);

    logic              mem_cs;
    logic              mem_wr;
    logic              mem_rd;
    logic [PAL_AW-1:0] addr;
    logic [15:0]       cpu_din;
    logic [15:0]       cpu_dout;
    logic              busy;

    modport master (output mem_cs, mem_wr, mem_rd, addr, cpu_din,
                    input  cpu_dout, busy);
    modport slave  (input  mem_cs, mem_wr, mem_rd, addr, cpu_din,
                    output cpu_dout, busy);

endinterface

// File: rtl/singleport_ram.sv
// Generic single-port synchronous RAM, one clock read latency, read-before-write.
module singleport_ram #(
    parameter int    widthad = 8,
    parameter int    width   = 8,
    parameter string name    = "RAM"
) (
    input  logic               clock,
    input  logic [widthad-1:0] address,
    input  logic               wren,
    input  logic [width-1:0]   data,
    output logic [width-1:0]   q
);

    logic [width-1:0] mem [0:(1<<widthad)-1];

    always_ff @(posedge clock) begin
        if (wren) mem[address] <= data;
        q <= mem[address];
    end

endmodule

// File: rtl/ga25_palette.sv
// GA25 palette lookup: time-shares one palette RAM between the pixel stream
// (ce_pix clocks) and CPU accesses (all other clocks), and aligns timing to RGB.
module ga25_palette
    import ga25_pkg::*;
#(
    parameter int PAL_AW          = 11,
    parameter bit DEF_BLANK_BLACK = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce_pix,
    ga25_palette_if.slave      bus,
    input  logic [10:0]        color_in,
    input  logic               hblank_in,
    input  logic               vblank_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hblank,
    output logic               vblank,
    output logic               hsync,
    output logic               vsync
);

    logic [1:0]        state, state_nxt;
    logic              req, req_prev, req_edge;
    logic [PAL_AW-1:0] lat_addr, ram_addr;
    logic [15:0]       lat_data, ram_q;
    logic              lat_wr, ram_we, vid_q;
    logic [14:0]       pix_latch;
    logic [3:0]        tim_s1;   // {hblank, vblank, hsync, vsync}

    assign req      = bus.mem_cs & (bus.mem_rd | bus.mem_wr);
    assign req_edge = req & ~req_prev & ~bus.busy;

    // Video owns every ce_pix clock; PEND only gets the RAM on a clock without it.
    assign ram_addr = ce_pix ? PAL_AW'(color_in) : lat_addr;
    assign ram_we   = (state == ST_PEND) & ~ce_pix & lat_wr;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_edge) state_nxt = ST_PEND;
            ST_PEND:  if (!ce_pix) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_CAPTURE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bus.busy     <= 1'b0;
            bus.cpu_dout <= '0;
            req_prev     <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            lat_wr       <= 1'b0;
        end else begin
            state    <= state_nxt;
            bus.busy <= (state_nxt != ST_IDLE);
            req_prev <= req;
            if (state == ST_IDLE && req_edge) begin
                lat_addr <= bus.addr;
                lat_data <= bus.cpu_din;
                lat_wr   <= bus.mem_wr;
            end
            // q still holds the CPU read on the clock leaving ISSUE.
            if (state == ST_ISSUE && !lat_wr) bus.cpu_dout <= ram_q;
        end
    end

    // ce_pix is never asserted on two adjacent clocks, so the latch is always
    // refreshed before the following ce_pix moves it to the RGB outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_q     <= 1'b0;
            pix_latch <= '0;
            tim_s1    <= 4'b1100;
            {hblank, vblank, hsync, vsync} <= 4'b1100;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
        end else begin
            vid_q <= ce_pix;
            if (vid_q) pix_latch <= ram_q[14:0];
            if (ce_pix) begin
                tim_s1 <= {hblank_in, vblank_in, hsync_in, vsync_in};
                {hblank, vblank, hsync, vsync} <= tim_s1;
                if (DEF_BLANK_BLACK && (tim_s1[3] || tim_s1[2])) begin
                    red   <= '0;
                    green <= '0;
                    blue  <= '0;
                end else begin
                    red   <= expand5(pix_latch[R_LSB +: C_W]);
                    green <= expand5(pix_latch[G_LSB +: C_W]);
                    blue  <= expand5(pix_latch[B_LSB +: C_W]);
                end
            end
        end
    end

    singleport_ram #(
        .widthad (PAL_AW),
        .width   (16),
        .name    ("PALRAM")
    ) u_palram (
        .clock   (clk),
        .address (ram_addr),
        .wren    (ram_we),
        .data    (lat_data),
        .q       (ram_q)
    );

endmodule

// File: tb/tb_ga25_palette.sv
// Randomized bench for ga25_palette: two instances (blanking forced / passed)
// share stimulus and are checked against a palette array model.
module tb_ga25_palette;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ce_pix = 1'b0;
    logic mem_cs = 1'b0, mem_wr = 1'b0, mem_rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0] cpu_din = '0;
    logic [10:0] color_in = '0;
    logic hblank_in = 1'b0, vblank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [7:0] red0, green0, blue0, red1, green1, blue1;
    logic hb0, vb0, hs0, vs0, hb1, vb1, hs1, vs1;

    ga25_palette_if #(.PAL_AW(AW)) bus0 ();
    ga25_palette_if #(.PAL_AW(AW)) bus1 ();

    assign bus0.mem_cs = mem_cs;  assign bus1.mem_cs = mem_cs;
    assign bus0.mem_wr = mem_wr;  assign bus1.mem_wr = mem_wr;
    assign bus0.mem_rd = mem_rd;  assign bus1.mem_rd = mem_rd;
    assign bus0.addr = addr;      assign bus1.addr = addr;
    assign bus0.cpu_din = cpu_din; assign bus1.cpu_din = cpu_din;

    ga25_palette #(.PAL_AW(AW), .DEF_BLANK_BLACK(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .bus(bus0),
        .color_in(color_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red(red0), .green(green0), .blue(blue0),
        .hblank(hb0), .vblank(vb0), .hsync(hs0), .vsync(vs0));

    ga25_palette #(.PAL_AW(AW), .DEF_BLANK_BLACK(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .bus(bus1),
        .color_in(color_in), .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red(red1), .green(green1), .blue(blue1),
        .hblank(hb1), .vblank(vb1), .hsync(hs1), .vsync(vs1));

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [15:0] mem_model [0:2047];
    int n_chk = 0, n_err = 0;
    int vid_period = 0, ph = 0;
    bit use_123 = 1'b0, fixed = 1'b0, have_prev = 1'b0;
    logic [10:0] fx_col = '0;
    logic fx_hb = 1'b0;
    logic [23:0] prev_raw, prev_blk;
    logic [3:0] prev_tim;
    logic [15:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb_of(input logic [15:0] e);
        int c[3];
        for (int k = 0; k < 3; k++) c[k] = (int'(e) >> (5 * k)) & 31;
        return {8'((c[0] << 3) | (c[0] >> 2)), 8'((c[1] << 3) | (c[1] >> 2)),
                8'((c[2] << 3) | (c[2] >> 2))};
    endfunction

    // One clock: check the pixel that just left the pipe, then pick next stimulus.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (ce_pix) begin
            if (have_prev) begin
                chk("rgb_blank_on", {red0, green0, blue0}, prev_blk);
                chk("rgb_blank_off", {red1, green1, blue1}, prev_raw);
                chk("timing", {hb0, vb0, hs0, vs0, hb1, vb1, hs1, vs1}, {prev_tim, prev_tim});
            end
            prev_raw = rgb_of(mem_model[color_in]);
            prev_blk = (hblank_in || vblank_in) ? 24'h0 : prev_raw;
            prev_tim = {hblank_in, vblank_in, hsync_in, vsync_in};
            have_prev = 1'b1;
        end
        if (vid_period == 0) ce_pix = 1'b0;
        else begin
            ph = (ph + 1) % vid_period;
            ce_pix = (ph == 0);
            if (ce_pix) begin
                hsync_in = 1'($urandom_range(0, 1));
                vsync_in = 1'($urandom_range(0, 1));
                if (fixed) begin
                    color_in = fx_col; hblank_in = fx_hb; vblank_in = 1'b0;
                end else begin
                    color_in = (use_123 && $urandom_range(0, 7) == 0) ? 11'h123
                                                                      : 11'($urandom_range(0, 31));
                    hblank_in = ($urandom_range(0, 5) == 0);
                    vblank_in = ($urandom_range(0, 7) == 0);
                end
            end
        end
    endtask

    task automatic wait_ce(input bit lvl);
        int k = 0;
        while (ce_pix != lvl && k < 10) begin k++; cyc(); end
    endtask

    task automatic cpu_op(input bit wr, input logic [10:0] a, input logic [15:0] d,
                          input int busy_exp, input string tag, output logic [15:0] rd);
        int nb = 0;
        mem_cs = 1'b1; mem_wr = wr; mem_rd = !wr; addr = a; cpu_din = d;
        cyc();
        while (bus0.busy && nb < 40) begin nb++; cyc(); end
        chk({tag, "_busy_end"}, bus0.busy, 0);
        if (busy_exp > 0) chk({tag, "_busy_len"}, nb, busy_exp);
        rd = bus0.cpu_dout;
        if (wr) begin
            mem_model[a] = d;
            chk({tag, "_dout_hold"}, rd, last_rd);
        end
        mem_cs = 1'b0; mem_wr = 1'b0; mem_rd = 1'b0;
        cyc();
    endtask

    task automatic rd_chk(input logic [10:0] a, input int busy_exp, input string tag);
        logic [15:0] rd;
        cpu_op(1'b0, a, 16'h0, busy_exp, tag, rd);
        chk({tag, "_data0"}, rd, mem_model[a]);
        chk({tag, "_data1"}, bus1.cpu_dout, mem_model[a]);
        last_rd = mem_model[a];
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, {bus0.busy, bus1.busy}, 0);
        chk({tag, "_dout"}, {bus0.cpu_dout, bus1.cpu_dout}, 0);
        chk({tag, "_rgb"}, {red0, green0, blue0, red1, green1, blue1}, 0);
        chk({tag, "_timing"}, {hb0, vb0, hs0, vs0, hb1, vb1, hs1, vs1}, 8'b1100_1100);
    endtask

    initial begin
        logic [15:0] rd, d1, d2;
        int cnt;

        repeat (3) cyc();
        chk_reset_state("reset");
        reset_n = 1'b1;
        cyc();

        // Fill the pixel address set and a CPU scratch area.
        for (int i = 0; i < 32; i++) cpu_op(1'b1, 11'(i), 16'($urandom), 3, "init_lo", rd);
        for (int i = 0; i < 16; i++) cpu_op(1'b1, 11'(12'h400 + i), 16'($urandom), 3, "init_hi", rd);

        // Idle write/readback with ce_pix 1-in-4.
        vid_period = 4;
        wait_ce(1'b1);
        cpu_op(1'b1, 11'h123, 16'h7C1F, 3, "wr123", rd);
        wait_ce(1'b1);
        rd_chk(11'h123, 3, "rd123");

        // Fixed colour 0x123 through the pixel path, then blanked.
        use_123 = 1'b1; fixed = 1'b1; fx_col = 11'h123; fx_hb = 1'b0;
        repeat (24) cyc();
        chk("rgb123", {red0, green0, blue0}, 24'hFF00FF);
        fx_hb = 1'b1;
        repeat (12) cyc();
        chk("blank_rgb", {red0, green0, blue0, hb0}, {24'h0, 1'b1});
        chk("blank_pass", {red1, green1, blue1, hb1}, {24'hFF00FF, 1'b1});
        fixed = 1'b0;

        // ce_pix 1-in-2: requests whose PEND lands on a pixel clock wait one clk.
        vid_period = 2;
        for (int k = 0; k < 8; k++) begin
            wait_ce(1'b0);
            cpu_op(1'b1, 11'(12'h400 + k), 16'($urandom), 4, "wr_coll", rd);
            wait_ce(1'b0);
            rd_chk(11'(12'h400 + k), 4, "rd_coll");
            wait_ce(1'b1);
            rd_chk(11'(12'h400 + k), 3, "rd_free");
        end

        // Held write level produces one write only.
        vid_period = 0;
        repeat (2) cyc();
        d1 = 16'($urandom); d2 = ~d1;
        mem_cs = 1'b1; mem_wr = 1'b1; addr = 11'h408; cpu_din = d1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus0.busy) cnt++;
            if (i == 4) cpu_din = d2;
        end
        chk("held_busy_clks", cnt, 3);
        mem_model[11'h408] = d1;
        mem_cs = 1'b0; mem_wr = 1'b0;
        cyc();
        rd_chk(11'h408, 3, "held_rd1");
        cpu_op(1'b1, 11'h408, d2, 3, "rewrite", rd);
        rd_chk(11'h408, 3, "held_rd2");

        // Reset during PEND of a write: write is dropped, held request taken after release.
        vid_period = 4;
        wait_ce(1'b1);
        mem_cs = 1'b1; mem_wr = 1'b1; mem_rd = 1'b0; addr = 11'h010; cpu_din = 16'h1234;
        cyc();
        chk("pend_busy", bus0.busy, 1);
        reset_n = 1'b0; vid_period = 0; ce_pix = 1'b0; have_prev = 1'b0;
        #1;
        chk_reset_state("mid_reset");
        mem_wr = 1'b0; mem_rd = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        cyc();
        chk("first_req_busy", bus0.busy, 1);
        cnt = 0;
        while (bus0.busy && cnt < 40) begin cnt++; cyc(); end
        chk("post_reset_rd", bus0.cpu_dout, mem_model[11'h010]);
        last_rd = mem_model[11'h010];
        mem_cs = 1'b0; mem_rd = 1'b0;
        cyc();

        // Random mix of pixel rates and CPU traffic.
        for (int k = 0; k < 24; k++) begin
            logic [10:0] a;
            vid_period = $urandom_range(2, 4);
            a = 11'(12'h400 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) cpu_op(1'b1, a, 16'($urandom), 0, "rnd_wr", rd);
            else rd_chk(a, 0, "rnd_rd");
            repeat ($urandom_range(0, 5)) cyc();
        end
        repeat (12) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ga25_palette.md
GA25_PALETTE -- requirements
Module: ga25_palette

Interface
REQ-001 SHALL have parameter PAL_AW, default 11, palette word-address width (2048 entries).
REQ-002 SHALL have parameter DEF_BLANK_BLACK, default 1, force RGB to zero while blanking.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ce_pix  in  1  pixel enable, same strobe as the tilemap stage.
REQ-006 SHALL have port mem_cs / mem_wr / mem_rd  in  1 each  CPU palette select, write, read.
REQ-007 SHALL have port addr  in  PAL_AW  CPU word address.
REQ-008 SHALL have ports cpu_din  in  16 and cpu_dout  out  16: CPU write data and read data.
REQ-009 SHALL have port busy  out  1  CPU access in progress; the CPU holds until low.
REQ-010 SHALL have port color_in  in  11  palette index from GA25 color_out.
REQ-011 SHALL have ports hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  timing from GA25.
REQ-012 SHALL have ports red, green, blue  out  8 each, and hblank, vblank, hsync, vsync  out  1 each: aligned video out.

Function
REQ-013 SHALL hold a single-port synchronous RAM of 2^PAL_AW x 16 with 1-clk read latency; entry format is xBBBBBGGGGGRRRRR.
REQ-014 SHALL allocate RAM slots as follows: a clk with ce_pix=1 is a video slot with RAM address color_in and no write; a clk with ce_pix=0 is a CPU slot.
REQ-015 SHALL capture RAM q into the pixel latch in the clk immediately after each video slot.
REQ-016 SHALL register red/green/blue on the next ce_pix from the pixel latch, giving a latency of exactly 2 ce_pix from color_in to RGB.
REQ-017 SHALL expand each 5-bit component c to 8 bits as {c, c[4:2]}, so 5'h1F gives 8'hFF and 0 gives 0.
REQ-018 SHALL delay all four timing signals through a 2-stage ce_pix shift so they align with RGB.
REQ-019 SHALL, when DEF_BLANK_BLACK=1 and delayed hblank or vblank is high, output RGB 0.
REQ-020 SHALL implement the CPU FSM states IDLE, PEND, ISSUE and CAPTURE.
REQ-021 SHALL detect a request as a rising edge of mem_cs&(mem_rd|mem_wr) while busy=0, then latch addr, cpu_din and write/read, and go IDLE->PEND.
REQ-022 SHALL move PEND->ISSUE in the first CPU slot, driving the RAM address and, for a write, the write enable with the latched data for that one clk.
REQ-023 SHALL move ISSUE->CAPTURE on the next clk; on a read, cpu_dout takes q at CAPTURE; CAPTURE->IDLE on the next clk.
REQ-024 SHALL drive busy high in PEND, ISSUE and CAPTURE; the minimum busy is 3 clks.
REQ-025 SHALL ignore a level held from a prior access; a new request needs a low then high edge.
REQ-026 SHALL let the video slot win when ce_pix=1 coincides with PEND; PEND then waits with no data loss.
REQ-027 SHALL make a write visible to the first video slot after its ISSUE clk, with no bypass.
REQ-028 SHALL hold cpu_dout unchanged on writes and hold the last read value otherwise.
REQ-029 SHALL define RAM contents as undefined after power-up; reset SHALL NOT clear the RAM.

Reset
REQ-030 SHALL, while reset_n=0, hold the FSM in IDLE, busy=0, cpu_dout=0, RGB=0, hsync=vsync=0, hblank=vblank=1, shift stages blank, and the edge detector's previous value=0.
REQ-031 SHALL, on reset mid-access, abandon the access; a write cancelled before ISSUE SHALL NOT reach RAM.
REQ-032 SHALL release reset without a glitch on busy, with the first request accepted 1 clk after deassertion.

Structure
REQ-033 SHALL keep the FSM state enum, the entry field positions and the expand function in shared package ga25_pkg.
REQ-034 SHALL use one sub-module, the existing singleport_ram (widthad=PAL_AW, width=16, name "PALRAM"); all else is in-module.

Verification
REQ-035 SHALL cover: write addr 0x123 = 16'h7C1F in idle, ce_pix 1-in-4 -> busy high 3 clks; readback gives 16'h7C1F.
REQ-036 SHALL cover: color_in=0x123, timing active -> after 2 ce_pix, red=8'hFF, green=8'h00, blue=8'hFF.
REQ-037 SHALL cover: ce_pix 1-in-2 (each request lands on a ce_pix clk) -> PEND holds 1 clk, busy high 4 clks, video RGB stream uncorrupted.
REQ-038 SHALL cover: hblank_in high with a nonzero entry -> RGB 0 and hblank high exactly 2 ce_pix later; with DEF_BLANK_BLACK=0 the colour passes.
REQ-039 SHALL cover: mem_wr held high 10 clks -> exactly one write; a second write needs a deassert then reassert.
REQ-040 SHALL cover: reset_n low during PEND of a write of 16'h1234 to 0x010 -> busy 0 at once; after reset, 0x010 keeps its old value.
